// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared CPU-side size encodings, data SRAM response defaults and queue entry layout
package mycpu_pkg;
  typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2} size_e;
  localparam int LAT_DEF = 2;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W = 3;
  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
  } resp_t;
  localparam int RESP_W = $bits(resp_t);
endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: in-order response queue; slot 0 is the head and every entry counts down to readiness
module resp_fifo
  import mycpu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = RESP_W,
  parameter int LAT   = LAT_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic         head_ready,
  output logic [W-1:0] head_data
);
  logic [DEPTH-1:0]                 vld_q, vld_d;
  logic [DEPTH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0][W-1:0]          dat_q, dat_d;
  logic [2:0]                       count_q, count_d, wr_idx;
  logic [DEPTH:0]                   vld_x;
  logic [DEPTH:0][CNT_W-1:0]        cnt_x;
  logic [DEPTH:0][W-1:0]            dat_x;
  assign full       = count_q == 3'(DEPTH);
  assign empty      = ~vld_q[0];
  assign head_ready = vld_q[0] && cnt_q[0] == '0;
  assign head_data  = dat_q[0];
  // one spare empty slot above the top so a pop can shift uniformly
  assign vld_x  = {1'b0, vld_q};
  assign cnt_x  = {{CNT_W{1'b0}}, cnt_q};
  assign dat_x  = {{W{1'b0}}, dat_q};
  assign wr_idx = count_q - {2'b0, pop};
  always_comb begin
    count_d = count_q + {2'b0, push} - {2'b0, pop};
    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i] = pop ? vld_x[i+1] : vld_x[i];
      dat_d[i] = pop ? dat_x[i+1] : dat_x[i];
      cnt_d[i] = pop ? cnt_x[i+1] : cnt_x[i];
      cnt_d[i] = cnt_d[i] - CNT_W'(cnt_d[i] != '0);
      if (push && wr_idx == 3'(i)) begin
        vld_d[i] = 1'b1;
        dat_d[i] = push_data;
        cnt_d[i] = CNT_W'(LAT - 1);
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: word-addressed data SRAM with byte-strobe writes and fixed-latency in-order responses
module data_sram_resp
  import mycpu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = LAT_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  logic [31:0]       mem_q [2**ADDR_W];
  logic [31:0]       mem_d;
  logic [ADDR_W-1:0] idx;
  logic              full, empty, head_ready;
  resp_t             push_e, head_e;
  logic              unused_ok;
  assign idx       = addr[ADDR_W+1:2];
  assign addr_ok   = resetn && req && !full;
  assign data_ok   = head_ready;
  assign rdata     = (data_ok && !head_e.is_wr) ? head_e.data : 32'h0;
  assign unused_ok = ^{size, empty, addr[31:ADDR_W+2], addr[1:0]};
  always_comb begin
    mem_d = mem_q[idx];
    for (int b = 0; b < 4; b++) mem_d[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : mem_d[8*b +: 8];
    push_e.is_wr = wr;
    push_e.data  = wr ? 32'h0 : mem_q[idx];
  end
  // the array is deliberately unreset so contents survive resetn
  always_ff @(posedge clk) begin
    if (addr_ok && wr) mem_q[idx] <= mem_d;
  end
  resp_fifo #(.DEPTH(DEPTH), .W(RESP_W), .LAT(LAT)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (addr_ok),
    .pop        (head_ready),
    .push_data  (push_e),
    .full       (full),
    .empty      (empty),
    .head_ready (head_ready),
    .head_data  (head_e)
  );
endmodule
